// File: rtl/control.sv
// rtl/control.sv - MIPS-style instruction decoder with a registered 32-bit control word
module control (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic [31:0] output_control
);

    localparam logic [5:0] OP_NOP   = 6'b000000;
    localparam logic [5:0] OP_RTYPE = 6'b000001;
    localparam logic [5:0] OP_LOAD  = 6'b000010;
    localparam logic [5:0] OP_STORE = 6'b000011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;

    localparam logic [1:0] CLS_NONE  = 2'b00;
    localparam logic [1:0] CLS_ALU   = 2'b01;
    localparam logic [1:0] CLS_LOAD  = 2'b10;
    localparam logic [1:0] CLS_STORE = 2'b11;

    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm16;

    assign opcode = instr[31:26];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];

    // rs feeds the register file straight from instr; shamt has no meaning here
    logic unused_fields;
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    logic [15:0] imm;
    logic [4:0]  wr_addr;
    logic [2:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src_imm;
    logic        illegal;
    logic [1:0]  cls;
    logic [31:0] decoded;

    always_comb begin
        imm         = 16'h0000;
        wr_addr     = 5'd0;
        alu_op      = ALU_ADD;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_imm = 1'b0;
        illegal     = 1'b0;
        cls         = CLS_NONE;

        unique case (opcode)
            OP_NOP: begin
            end
            OP_RTYPE: begin
                wr_addr   = rd;
                reg_write = 1'b1;
                cls       = CLS_ALU;
                case (funct)
                    6'b100000: alu_op = ALU_ADD;
                    6'b100010: alu_op = ALU_SUB;
                    6'b100100: alu_op = ALU_AND;
                    6'b100101: alu_op = ALU_OR;
                    6'b110010: alu_op = ALU_MUL;
                    default: begin
                        // unknown funct collapses to the canonical illegal word
                        wr_addr   = 5'd0;
                        reg_write = 1'b0;
                        cls       = CLS_NONE;
                        illegal   = 1'b1;
                    end
                endcase
            end
            OP_LOAD: begin
                imm         = imm16;
                wr_addr     = rt;
                reg_write   = 1'b1;
                mem_read    = 1'b1;
                mem_to_reg  = 1'b1;
                alu_src_imm = 1'b1;
                cls         = CLS_LOAD;
            end
            OP_STORE: begin
                imm         = imm16;
                mem_write   = 1'b1;
                alu_src_imm = 1'b1;
                cls         = CLS_STORE;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign decoded = {imm, wr_addr, alu_op, reg_write, mem_read, mem_write,
                      mem_to_reg, alu_src_imm, illegal, cls};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_control <= 32'h0000_0000;
        end else begin
            output_control <= decoded;
        end
    end

endmodule

// File: tb/tb_control.sv
// tb/tb_control.sv - randomized self-checking bench for the control decoder
module tb_control;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] output_control;

    int checks;
    int failures;

    control dut (
        .clk            (clk),
        .rst            (rst),
        .instr          (instr),
        .output_control (output_control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode built from the field-map arithmetic, not a bit-level mux
    function automatic logic [31:0] model(input logic [31:0] i);
        int op, rt, rd, funct, imm, alu;
        int legal_funct[5] = '{32, 34, 36, 37, 50};
        op    = int'(i >> 26);
        rt    = int'((i >> 16) & 32'h1F);
        rd    = int'((i >> 11) & 32'h1F);
        funct = int'(i & 32'h3F);
        imm   = int'(i & 32'hFFFF);
        case (op)
            0: return 32'd0;
            1: begin
                alu = -1;
                for (int k = 0; k < 5; k++)
                    if (legal_funct[k] == funct) alu = k;
                if (alu < 0) return 32'd4;
                return 32'(rd * 2048 + alu * 256 + 128 + 1);
            end
            2: return 32'(imm * 65536 + rt * 2048 + 128 + 64 + 16 + 8 + 2);
            3: return 32'(imm * 65536 + 32 + 8 + 3);
            default: return 32'd4;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int legal_funct[5] = '{32, 34, 36, 37, 50};
        r = $urandom;
        case ($urandom_range(0, 5))
            0: r[31:26] = 6'd0;
            1, 2: begin
                r[31:26] = 6'd1;
                if ($urandom_range(0, 3) != 0)
                    r[5:0] = 6'(legal_funct[$urandom_range(0, 4)]);
            end
            3: r[31:26] = 6'd2;
            4: r[31:26] = 6'd3;
            default: ;
        endcase
        return r;
    endfunction

    task automatic apply(input logic [31:0] v);
        @(negedge clk);
        instr = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        instr = 32'h0A19_0000;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (output_control !== 32'h0) begin
            $display("FAIL reset_hold got=%h exp=%h", output_control, 32'h0);
            failures++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (output_control !== model(32'h0A19_0000)) begin
            $display("FAIL reset_first_edge got=%h exp=%h", output_control, model(32'h0A19_0000));
            failures++;
        end
    endtask

    task automatic test_directed();
        logic [31:0] vec [11] = '{32'h08A0_1900, 32'h08A1_1901, 32'h0401_4332,
                                  32'h0443_4AA0, 32'h0509_52A2, 32'h0400_4825,
                                  32'h0400_4824, 32'h0CAA_1CFF, 32'hFC00_0000,
                                  32'h0400_4807, 32'h0000_0000};
        logic [31:0] exp [11] = '{32'h1900_00DA, 32'h1901_08DA, 32'h0000_4481,
                                  32'h0000_4881, 32'h0000_5181, 32'h0000_4B81,
                                  32'h0000_4A81, 32'h1CFF_002B, 32'h0000_0004,
                                  32'h0000_0004, 32'h0000_0000};
        for (int k = 0; k < 11; k++) begin
            apply(vec[k]);
            checks++;
            if (output_control !== exp[k]) begin
                $display("FAIL directed[%0d] instr=%h got=%h exp=%h", k, vec[k], output_control, exp[k]);
                failures++;
            end
        end
    endtask

    task automatic test_hold_between_edges();
        logic [31:0] first;
        first = 32'h0CAA_1CFF;
        apply(first);
        #2 instr = 32'h0401_4332;
        #1;
        checks++;
        if (output_control !== model(first)) begin
            $display("FAIL hold_between_edges got=%h exp=%h", output_control, model(first));
            failures++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (output_control !== model(32'h0401_4332)) begin
            $display("FAIL hold_next_edge got=%h exp=%h", output_control, model(32'h0401_4332));
            failures++;
        end
    endtask

    task automatic test_async_reset_midstream();
        apply(32'h08A1_1901);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (output_control !== 32'h0) begin
            $display("FAIL async_reset got=%h exp=%h", output_control, 32'h0);
            failures++;
        end
        instr = 32'h0443_4AA0;
        @(posedge clk);
        #1;
        checks++;
        if (output_control !== 32'h0) begin
            $display("FAIL reset_held_over_edge got=%h exp=%h", output_control, 32'h0);
            failures++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (output_control !== model(32'h0443_4AA0)) begin
            $display("FAIL post_reset_decode got=%h exp=%h", output_control, model(32'h0443_4AA0));
            failures++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [6] = '{32'h08A1_1901, 32'h0401_4332, 32'h0CAA_1CFF,
                                 32'h08A0_1900, 32'h0CAA_1CFF, 32'h0401_4332};
        for (int k = 0; k < 6; k++) begin
            apply(seq[k]);
            checks++;
            if (output_control !== model(seq[k])) begin
                $display("FAIL back_to_back[%0d] got=%h exp=%h", k, output_control, model(seq[k]));
                failures++;
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int k = 0; k < 400; k++) begin
            v = rand_instr();
            apply(v);
            checks++;
            if (output_control !== model(v)) begin
                $display("FAIL random[%0d] instr=%h got=%h exp=%h", k, v, output_control, model(v));
                failures++;
            end
            checks++;
            if (output_control[7] === 1'b1 && output_control[5] === 1'b1) begin
                $display("FAIL write_safety[%0d] got=%h exp=not_both_writes", k, output_control);
                failures++;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        instr    = 32'h0;
        test_reset();
        test_directed();
        test_hold_between_edges();
        test_async_reset_midstream();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
